// File: rtl/hqc_rmencod.sv
// hqc_rmencod: RM(1,7) encoder for the HQC concatenated code.
// Each accepted RS byte becomes a 128-bit codeword that is streamed
// MULTIPLICITY times as DOUT_W-bit words; a session spans N1 bytes.
// Optional sticky protocol error flag: define HQC_RMENCOD_ERR_EN.
module hqc_rmencod #(
    parameter int unsigned PARAM_SECURITY = 128,
    parameter int unsigned MULTIPLICITY   = (PARAM_SECURITY == 128) ? 3 : 5,
    parameter int unsigned N1             = (PARAM_SECURITY == 128) ? 46 :
                                            (PARAM_SECURITY == 192) ? 56 : 90,
    parameter int unsigned DOUT_W         = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [7:0]        din_i,
    input  logic              din_valid_i,
    output logic              din_ready_o,
    output logic [DOUT_W-1:0] dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned CW_W   = 128;
    localparam int unsigned WPC    = CW_W / DOUT_W;
    localparam int unsigned SYM_W  = (N1 > 1) ? $clog2(N1) : 1;
    localparam int unsigned WCNT_W = (WPC > 1) ? $clog2(WPC) : 1;
    localparam int unsigned REP_W  = 3;

    localparam logic [SYM_W-1:0]  SYM_LAST  = SYM_W'(N1 - 1);
    localparam logic [WCNT_W-1:0] WORD_LAST = WCNT_W'(WPC - 1);
    localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(MULTIPLICITY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [SYM_W-1:0]    sym_cnt_q, sym_cnt_d;
    logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [REP_W-1:0]    rep_cnt_q, rep_cnt_d;
    logic [CW_W-1:0]     cw_q, cw_d;
    logic                done_q, done_d;
    logic [CW_W-1:0]     cw_c;
    logic                last_word;
    logic                last_sym;
    logic                dout_hs;
    logic                din_hs;

    // RM(1,7) expansion: bit i = m0 ^ <m[7:1], i[6:0]>
    always_comb begin
        cw_c = '0;
        for (int i = 0; i < 128; i++) begin
            cw_c[i] = din_i[0] ^ (^(din_i[7:1] & 7'(i)));
        end
    end

    assign last_word = (word_cnt_q == WORD_LAST) && (rep_cnt_q == REP_LAST);
    assign last_sym  = (sym_cnt_q == SYM_LAST);
    assign dout_hs   = (state_q == EMIT) && dout_ready_i;
    assign din_hs    = din_ready_o && din_valid_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = LOAD;
            end
            LOAD: begin
                if (din_valid_i) state_d = EMIT;
            end
            EMIT: begin
                if (dout_hs && last_word) begin
                    if (last_sym)         state_d = IDLE;
                    else if (!din_valid_i) state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode; din_ready_o follows dout_ready_i only on a non-final last word
    always_comb begin
        din_ready_o  = 1'b0;
        dout_valid_o = 1'b0;
        busy_o       = 1'b0;
        case (state_q)
            IDLE: ;
            LOAD: begin
                din_ready_o = 1'b1;
                busy_o      = 1'b1;
            end
            EMIT: begin
                dout_valid_o = 1'b1;
                busy_o       = 1'b1;
                if (last_word && !last_sym) din_ready_o = dout_ready_i;
            end
            default: ;
        endcase
    end

    // Counter, codeword and done update
    always_comb begin
        sym_cnt_d  = sym_cnt_q;
        word_cnt_d = word_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        cw_d       = cw_q;
        done_d     = 1'b0;
        if ((state_q == IDLE) && start_i) begin
            sym_cnt_d = '0;
        end
        if (dout_hs) begin
            if (word_cnt_q == WORD_LAST) begin
                word_cnt_d = '0;
                rep_cnt_d  = rep_cnt_q + REP_W'(1);
            end else begin
                word_cnt_d = word_cnt_q + WCNT_W'(1);
            end
            if (last_word) begin
                sym_cnt_d = sym_cnt_q + SYM_W'(1);
                done_d    = last_sym;
            end
        end
        if (din_hs) begin
            cw_d       = cw_c;
            word_cnt_d = '0;
            rep_cnt_d  = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sym_cnt_q  <= '0;
            word_cnt_q <= '0;
            rep_cnt_q  <= '0;
            cw_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            sym_cnt_q  <= sym_cnt_d;
            word_cnt_q <= word_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            cw_q       <= cw_d;
            done_q     <= done_d;
        end
    end

    assign dout_o = cw_q[DOUT_W * 32'(word_cnt_q) +: DOUT_W];
    assign done_o = done_q;

`ifdef HQC_RMENCOD_ERR_EN
    logic err_q, err_d;

    // Sticky error: start while busy or data offered while idle; idle start clears
    always_comb begin
        err_d = err_q;
        if (start_i && (state_q == IDLE)) err_d = 1'b0;
        if ((start_i && busy_o) || (din_valid_i && (state_q == IDLE))) err_d = 1'b1;
    end

    // Error flag register
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_hqc_rmencod.sv
// tb_hqc_rmencod: directed and randomized checks for hqc_rmencod
// (PARAM_SECURITY=128, DOUT_W=32: 46 symbols x 3 copies x 4 words).
`timescale 1ns/1ps
module tb_hqc_rmencod;

    localparam int N1        = 46;
    localparam int WPC       = 4;
    localparam int MULT      = 3;
    localparam int SYM_WORDS = WPC * MULT;
    localparam int TOTAL     = N1 * SYM_WORDS;
`ifdef HQC_RMENCOD_ERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_ni;
    logic        start_i;
    logic [7:0]  din_i;
    logic        din_valid_i;
    logic        din_ready_o;
    logic [31:0] dout_o;
    logic        dout_valid_o;
    logic        dout_ready_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    int          n_checks  = 0;
    int          n_errors  = 0;
    int          cyc       = 0;
    logic [31:0] got_q[$];
    int          first_hs  = -1;
    int          last_hs   = -1;
    int          word_in_sym = 0;
    int          ready_viol = 0;
    int          stall_err = 0;
    int          done_cnt  = 0;
    int          done_cyc  = 0;
    logic        done_busy = 1'b0;
    logic        rnd_ready = 1'b0;
    logic        prev_v    = 1'b0;
    logic        prev_r    = 1'b0;
    logic [31:0] prev_d    = '0;

    hqc_rmencod #(
        .PARAM_SECURITY(128),
        .DOUT_W        (32)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .din_i       (din_i),
        .din_valid_i (din_valid_i),
        .din_ready_o (din_ready_o),
        .dout_o      (dout_o),
        .dout_valid_o(dout_valid_o),
        .dout_ready_i(dout_ready_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Downstream ready: always high or a 50% coin flip per cycle
    initial forever begin
        @(posedge clk);
        #1;
        dout_ready_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Golden word from the generator-matrix rows of RM(1,7)
    function automatic logic [31:0] exp_word(input logic [7:0] m, input int w);
        logic [31:0] r;
        r = m[0] ? 32'hFFFF_FFFF : 32'h0;
        if (m[1]) r ^= 32'hAAAA_AAAA;
        if (m[2]) r ^= 32'hCCCC_CCCC;
        if (m[3]) r ^= 32'hF0F0_F0F0;
        if (m[4]) r ^= 32'hFF00_FF00;
        if (m[5]) r ^= 32'hFFFF_0000;
        if (m[6] && w[0]) r ^= 32'hFFFF_FFFF;
        if (m[7] && w[1]) r ^= 32'hFFFF_FFFF;
        return r;
    endfunction

    // Output monitor: collects transferred words and protocol observations
    initial forever begin
        @(negedge clk);
        if (rst_ni) begin
            if (dout_valid_o && din_ready_o && (word_in_sym != SYM_WORDS - 1)) ready_viol++;
            if (prev_v && !prev_r && (!dout_valid_o || (dout_o !== prev_d))) stall_err++;
            if (dout_valid_o && dout_ready_i) begin
                got_q.push_back(dout_o);
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                word_in_sym = (word_in_sym == SYM_WORDS - 1) ? 0 : word_in_sym + 1;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc  = cyc;
                done_busy = busy_o;
            end
        end
        prev_v = dout_valid_o && rst_ni;
        prev_r = dout_ready_i;
        prev_d = dout_o;
    end

    task automatic clear_mon();
        got_q.delete();
        first_hs    = -1;
        last_hs     = -1;
        word_in_sym = 0;
        ready_viol  = 0;
        stall_err   = 0;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_dout"},       dout_o,              32'h0);
        check({pfx, "_dout_valid"}, 32'(dout_valid_o),   32'h0);
        check({pfx, "_din_ready"},  32'(din_ready_o),    32'h0);
        check({pfx, "_busy"},       32'(busy_o),         32'h0);
        check({pfx, "_done"},       32'(done_o),         32'h0);
        check({pfx, "_err"},        32'(err_o),          32'h0);
    endtask

    // One full session; err_at >= 0 pulses start_i while that symbol is pending
    task automatic run_session(input logic [7:0] syms[$], input int err_at);
        int          idx   = 0;
        int          guard = 0;
        int          d0    = done_cnt;
        int          inj   = 0;
        logic [31:0] exp_q[$];
        clear_mon();
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("ready_after_start", 32'(din_ready_o), 32'h1);
        check("busy_after_start",  32'(busy_o),      32'h1);
        @(posedge clk); #1;
        while (idx < syms.size() && guard < 10000) begin
            din_i       = syms[idx];
            din_valid_i = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i     = 1'b0;
            if (inj == 1) inj = 2;
            else if (inj == 0 && err_at >= 0 && idx == err_at) begin
                start_i = 1'b1;
                inj = 1;
            end
            @(negedge clk);
            if (inj == 2) begin
                check("err_after_busy_start", 32'(err_o), 32'(ERR_EN));
                inj = 3;
            end
            if (din_valid_i && din_ready_o) idx++;
            @(posedge clk); #1;
            guard++;
        end
        din_valid_i = 1'b0;
        start_i     = 1'b0;
        check("feed_timeout", 32'(idx), 32'(syms.size()));
        guard = 0;
        while (done_cnt == d0 && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_once", 32'(done_cnt - d0), 32'd1);
        foreach (syms[s])
            for (int r = 0; r < MULT; r++)
                for (int w = 0; w < WPC; w++)
                    exp_q.push_back(exp_word(syms[s], w));
        check("word_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("word%0d", i), got_q[i], exp_q[i]);
        check("ready_mid_symbol", 32'(ready_viol), 32'd0);
        check("stall_stable",     32'(stall_err),  32'd0);
        check("done_after_last",  32'(done_cyc),   32'(last_hs + 1));
        check("busy_at_done",     32'(done_busy),  32'd0);
    endtask

    initial begin
        logic [7:0] syms[$];
        int         guard;
        int         d0;
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        din_i        = 8'h00;
        din_valid_i  = 1'b0;
        dout_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_ni = 1'b1;

        // Directed symbols at the head of a full session, ready held high
        syms = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h80};
        while (syms.size() < N1) syms.push_back(8'($urandom_range(0, 255)));
        rnd_ready = 1'b0;
        run_session(syms, -1);
        for (int i = 0; i < SYM_WORDS; i++) begin
            check("m00", got_q[i],                 32'h0000_0000);
            check("m01", got_q[SYM_WORDS + i],     32'hFFFF_FFFF);
            check("m02", got_q[2 * SYM_WORDS + i], 32'hAAAA_AAAA);
            check("m03", got_q[3 * SYM_WORDS + i], 32'h5555_5555);
            check("m80", got_q[4 * SYM_WORDS + i], ((i % 4) < 2) ? 32'h0 : 32'hFFFF_FFFF);
        end
        check("no_gaps", 32'(last_hs - first_hs + 1), 32'(TOTAL));
        check("err_clean", 32'(err_o), 32'h0);

        // Reset mid-session, during symbol 3
        clear_mon();
        d0 = done_cnt;
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i     = 1'b0;
        din_i       = 8'h5A;
        din_valid_i = 1'b1;
        guard = 0;
        while (got_q.size() < 3 * SYM_WORDS + 6 && guard < 2000) begin
            @(posedge clk); #1;
            guard++;
        end
        check("rst_reach_word", 32'(got_q.size()), 32'(3 * SYM_WORDS + 6));
        rst_ni = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("midrst");
        rst_ni      = 1'b1;
        din_valid_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_idle",    32'(busy_o),        32'd0);

        // Random stalls on both sides after the restart
        syms.delete();
        while (syms.size() < N1) syms.push_back(8'($urandom_range(0, 255)));
        rnd_ready = 1'b1;
        run_session(syms, -1);

        // Start pulse while busy
        rnd_ready = 1'b0;
        run_session(syms, 10);
        check("err_sticky", 32'(err_o), 32'(ERR_EN));
        @(posedge clk); #1;
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        check("err_clear_idle_start", 32'(err_o), 32'h0);
        @(posedge clk); #1;
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk); #1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
